// File: rtl/store_merge_unit_pkg.sv
// Shared encodings and helpers for the store merge unit.
package store_merge_unit_pkg;

   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned LANE_W   = 2;

   localparam logic [FUNCT3_W-1:0] STORE_SB = 3'b000;
   localparam logic [FUNCT3_W-1:0] STORE_SH = 3'b001;
   localparam logic [FUNCT3_W-1:0] STORE_SW = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_REQ  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_WR_REQ  = 2'd3
   } state_t;

   // Legal store width with natural alignment for that width.
   function automatic logic store_legal(input logic [FUNCT3_W-1:0] funct3,
                                        input logic [LANE_W-1:0]   addr_lo);
      logic ok;
      case (funct3)
         STORE_SB: ok = 1'b1;
         STORE_SH: ok = ~addr_lo[0];
         STORE_SW: ok = (addr_lo == 2'b00);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Store request bus plus word-memory command/response bus.
interface store_merge_unit_if #(
   parameter int unsigned WIDTH_ADDR = 32,
   parameter int unsigned WIDTH_DATA = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_funct3;
   logic [WIDTH_ADDR-1:0] req_addr;
   logic [WIDTH_DATA-1:0] req_data;
   logic                  mem_req_valid;
   logic                  mem_req_we;
   logic [WIDTH_ADDR-1:0] mem_req_addr;
   logic [WIDTH_DATA-1:0] mem_req_wdata;
   logic                  mem_req_ready;
   logic                  mem_rsp_valid;
   logic [WIDTH_DATA-1:0] mem_rsp_rdata;
   logic                  done;
   logic                  err;

   // Merge unit side.
   modport slave (
      input  req_valid, req_funct3, req_addr, req_data,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      output done, err
   );

   // Store issuer and memory side.
   modport master (
      output req_valid, req_funct3, req_addr, req_data,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      input  done, err
   );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge of sub-word store data into an old word.
module store_lane_merge
   import store_merge_unit_pkg::*;
(
   input  logic [FUNCT3_W-1:0] funct3,
   input  logic [LANE_W-1:0]   addr_lo,
   input  logic [31:0]         data,
   input  logic [31:0]         old_word,
   output logic [31:0]         merged_c
);

   // Replace only the lanes the store covers; little-endian lane order.
   always_comb begin
      merged_c = old_word;
      case (funct3)
         STORE_SB: merged_c[{addr_lo, 3'b000} +: 8]     = data[7:0];
         STORE_SH: merged_c[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
         STORE_SW: merged_c = data;
         default:  merged_c = old_word;
      endcase
   end

endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store executor: read word, merge lanes, write word back.
// A one-entry last-word buffer skips the read for repeat stores to one word.
module store_merge_unit
   import store_merge_unit_pkg::*;
#(
   parameter int unsigned WIDTH_ADDR    = 32,
   parameter int unsigned WIDTH_DATA    = 32,
   parameter int unsigned USE_LAST_WORD = 1
) (
   input logic              clk,
   input logic              rst,
   store_merge_unit_if.slave bus
);

   localparam int unsigned TAG_W = WIDTH_ADDR - 2;

   state_t                state_q;
   logic                  req_ready_q;
   logic                  mem_req_valid_q;
   logic                  mem_req_we_q;
   logic [WIDTH_ADDR-1:0] mem_req_addr_q;
   logic [WIDTH_DATA-1:0] mem_req_wdata_q;
   logic                  done_q;
   logic                  err_q;

   logic [FUNCT3_W-1:0]   funct3_q;
   logic [LANE_W-1:0]     addr_lo_q;
   logic [WIDTH_DATA-1:0] data_q;

   logic                  buf_valid_q;
   logic [TAG_W-1:0]      buf_tag_q;
   logic [WIDTH_DATA-1:0] buf_word_q;

   logic                  idle_c;
   logic                  accept_c;
   logic                  legal_c;
   logic                  hit_c;
   logic [WIDTH_ADDR-1:0] word_addr_c;
   logic [FUNCT3_W-1:0]   mrg_funct3_c;
   logic [LANE_W-1:0]     mrg_addr_lo_c;
   logic [WIDTH_DATA-1:0] mrg_data_c;
   logic [WIDTH_DATA-1:0] mrg_old_c;
   logic [WIDTH_DATA-1:0] merged_c;

   assign idle_c      = (state_q == ST_IDLE);
   assign accept_c    = bus.req_valid && req_ready_q;
   assign legal_c     = store_legal(bus.req_funct3, bus.req_addr[1:0]);
   assign hit_c       = (USE_LAST_WORD != 0) && buf_valid_q &&
                        (bus.req_addr[WIDTH_ADDR-1:2] == buf_tag_q);
   assign word_addr_c = {bus.req_addr[WIDTH_ADDR-1:2], 2'b00};

   // In IDLE merge the incoming request over the buffered word; later the latched request over read data.
   assign mrg_funct3_c  = idle_c ? bus.req_funct3    : funct3_q;
   assign mrg_addr_lo_c = idle_c ? bus.req_addr[1:0] : addr_lo_q;
   assign mrg_data_c    = idle_c ? bus.req_data      : data_q;
   assign mrg_old_c     = idle_c ? buf_word_q        : bus.mem_rsp_rdata;

   store_lane_merge u_lane_merge (
      .funct3   (mrg_funct3_c),
      .addr_lo  (mrg_addr_lo_c),
      .data     (mrg_data_c),
      .old_word (mrg_old_c),
      .merged_c (merged_c)
   );

   // Control FSM with registered memory command, pulses and last-word buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_req_we_q    <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         funct3_q        <= '0;
         addr_lo_q       <= '0;
         data_q          <= '0;
         buf_valid_q     <= 1'b0;
         buf_tag_q       <= '0;
         buf_word_q      <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  funct3_q  <= bus.req_funct3;
                  addr_lo_q <= bus.req_addr[1:0];
                  data_q    <= bus.req_data;
                  if (!legal_c) begin
                     err_q <= 1'b1;
                  end else if ((bus.req_funct3 == STORE_SW) || hit_c) begin
                     state_q         <= ST_WR_REQ;
                     req_ready_q     <= 1'b0;
                     mem_req_valid_q <= 1'b1;
                     mem_req_we_q    <= 1'b1;
                     mem_req_addr_q  <= word_addr_c;
                     mem_req_wdata_q <= merged_c;
                  end else begin
                     state_q         <= ST_RD_REQ;
                     req_ready_q     <= 1'b0;
                     mem_req_valid_q <= 1'b1;
                     mem_req_we_q    <= 1'b0;
                     mem_req_addr_q  <= word_addr_c;
                  end
               end
            end
            ST_RD_REQ: begin
               if (bus.mem_req_ready) begin
                  state_q         <= ST_RD_WAIT;
                  mem_req_valid_q <= 1'b0;
               end
            end
            ST_RD_WAIT: begin
               if (bus.mem_rsp_valid) begin
                  state_q         <= ST_WR_REQ;
                  mem_req_valid_q <= 1'b1;
                  mem_req_we_q    <= 1'b1;
                  mem_req_wdata_q <= merged_c;
               end
            end
            ST_WR_REQ: begin
               if (bus.mem_req_ready) begin
                  state_q         <= ST_IDLE;
                  req_ready_q     <= 1'b1;
                  mem_req_valid_q <= 1'b0;
                  mem_req_we_q    <= 1'b0;
                  done_q          <= 1'b1;
                  buf_valid_q     <= 1'b1;
                  buf_tag_q       <= mem_req_addr_q[WIDTH_ADDR-1:2];
                  buf_word_q      <= mem_req_wdata_q;
               end
            end
            default: begin
               state_q         <= ST_IDLE;
               req_ready_q     <= 1'b1;
               mem_req_valid_q <= 1'b0;
               mem_req_we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_we    = mem_req_we_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign bus.mem_req_wdata = mem_req_wdata_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: merge results, latency, stalls, errors, buffer, reset.
module tb_store_merge_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   int   wr_base;
   int   rd_base;

   store_merge_unit_if #(.WIDTH_ADDR(32), .WIDTH_DATA(32)) bus ();

   store_merge_unit #(.WIDTH_ADDR(32), .WIDTH_DATA(32), .USE_LAST_WORD(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Count accepted memory commands.
   always @(posedge clk) begin
      if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
         if (bus.mem_req_we) wr_cnt++;
         else                rd_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; the unit must be ready.
   task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      check("req_ready_before_issue", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_data   = data;
      tick();
      bus.req_valid  = 1'b0;
   endtask

   task automatic check_cmd(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic chk_wdata);
      check({tag, "_valid"}, 32'(bus.mem_req_valid), 32'd1);
      check({tag, "_we"},    32'(bus.mem_req_we),    32'(we));
      check({tag, "_addr"},  bus.mem_req_addr,       addr);
      if (chk_wdata) check({tag, "_wdata"}, bus.mem_req_wdata, wdata);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready),     32'd1);
      check({tag, "_valid"},     32'(bus.mem_req_valid), 32'd0);
      check({tag, "_we"},        32'(bus.mem_req_we),    32'd0);
      check({tag, "_addr"},      bus.mem_req_addr,       32'd0);
      check({tag, "_wdata"},     bus.mem_req_wdata,      32'd0);
      check({tag, "_done"},      32'(bus.done),          32'd0);
      check({tag, "_err"},       32'(bus.err),           32'd0);
   endtask

   initial begin
      bus.req_valid     = 1'b0;
      bus.req_funct3    = 3'b000;
      bus.req_addr      = 32'd0;
      bus.req_data      = 32'd0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 32'd0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // sb 0x103 over 0x11223344: read, merge, write; done 4 cycles after accept.
      issue(3'b000, 32'h103, 32'hAB);
      check_cmd("sb_rd", 1'b0, 32'h100, 32'h0, 1'b0);
      check("sb_rd_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      check("sb_rdwait_valid", 32'(bus.mem_req_valid), 32'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h11223344;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check_cmd("sb_wr", 1'b1, 32'h100, 32'hAB223344, 1'b1);
      check("sb_wr_done_early", 32'(bus.done), 32'd0);
      tick();
      check("sb_done", 32'(bus.done), 32'd1);
      check("sb_idle_ready", 32'(bus.req_ready), 32'd1);
      check("sb_idle_valid", 32'(bus.mem_req_valid), 32'd0);
      tick();
      check("sb_done_pulse", 32'(bus.done), 32'd0);

      // sh 0x202 over 0xDEADC0DE: upper halfword.
      issue(3'b001, 32'h202, 32'h0000BEEF);
      check_cmd("sh_rd", 1'b0, 32'h200, 32'h0, 1'b0);
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hDEADC0DE;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check_cmd("sh_wr", 1'b1, 32'h200, 32'hBEEFC0DE, 1'b1);
      tick();
      check("sh_done", 32'(bus.done), 32'd1);

      // sw 0x300: direct write, no read, done 2 cycles after accept.
      rd_base = rd_cnt;
      wr_base = wr_cnt;
      issue(3'b010, 32'h300, 32'hCAFEF00D);
      check_cmd("sw_wr", 1'b1, 32'h300, 32'hCAFEF00D, 1'b1);
      tick();
      check("sw_done", 32'(bus.done), 32'd1);
      check("sw_no_read", 32'(rd_cnt - rd_base), 32'd0);
      check("sw_one_write", 32'(wr_cnt - wr_base), 32'd1);

      // Misaligned sh and illegal funct3: error pulse, no traffic.
      rd_base = rd_cnt;
      wr_base = wr_cnt;
      issue(3'b001, 32'h101, 32'h1234);
      check("mis_sh_err", 32'(bus.err), 32'd1);
      check("mis_sh_valid", 32'(bus.mem_req_valid), 32'd0);
      check("mis_sh_ready", 32'(bus.req_ready), 32'd1);
      tick();
      check("mis_sh_err_pulse", 32'(bus.err), 32'd0);
      issue(3'b011, 32'h100, 32'h1234);
      check("bad_f3_err", 32'(bus.err), 32'd1);
      check("bad_f3_valid", 32'(bus.mem_req_valid), 32'd0);
      check("bad_f3_ready", 32'(bus.req_ready), 32'd1);
      issue(3'b010, 32'h302, 32'h1234);
      check("mis_sw_err", 32'(bus.err), 32'd1);
      check("mis_sw_valid", 32'(bus.mem_req_valid), 32'd0);
      tick();
      check("err_no_traffic", 32'((rd_cnt - rd_base) + (wr_cnt - wr_base)), 32'd0);

      // Backpressure: command held stable 5 cycles in each request state.
      wr_base = wr_cnt;
      bus.mem_req_ready = 1'b0;
      issue(3'b000, 32'h500, 32'h5A);
      for (int i = 0; i < 5; i++) begin
         check_cmd("stall_rd", 1'b0, 32'h500, 32'h0, 1'b0);
         tick();
      end
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h01020304;
      bus.mem_req_ready = 1'b0;
      tick();
      bus.mem_rsp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_cmd("stall_wr", 1'b1, 32'h500, 32'h0102035A, 1'b1);
         check("stall_wr_done", 32'(bus.done), 32'd0);
         tick();
      end
      bus.mem_req_ready = 1'b1;
      tick();
      check("stall_done", 32'(bus.done), 32'd1);
      tick();
      check("stall_one_write", 32'(wr_cnt - wr_base), 32'd1);

      // Last-word buffer: second sb to the same word skips the read.
      issue(3'b000, 32'h400, 32'h11);
      check_cmd("buf_first_rd", 1'b0, 32'h400, 32'h0, 1'b0);
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h00000000;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check_cmd("buf_first_wr", 1'b1, 32'h400, 32'h00000011, 1'b1);
      tick();
      check("buf_first_done", 32'(bus.done), 32'd1);
      rd_base = rd_cnt;
      issue(3'b000, 32'h401, 32'h22);
      check_cmd("buf_hit_wr", 1'b1, 32'h400, 32'h00002211, 1'b1);
      tick();
      check("buf_hit_done", 32'(bus.done), 32'd1);
      check("buf_hit_no_read", 32'(rd_cnt - rd_base), 32'd0);

      // Reset in RD_WAIT abandons the store; a late response is ignored.
      wr_base = wr_cnt;
      issue(3'b000, 32'h600, 32'h77);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("rst_mid");
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hFFFFFFFF;
      tick();
      bus.mem_rsp_valid = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst_late_rsp");
      check("rst_no_write", 32'(wr_cnt - wr_base), 32'd0);

      // Buffer was invalidated by reset: a sub-store to the old word must read again.
      issue(3'b000, 32'h401, 32'h33);
      check_cmd("rst_buf_miss", 1'b0, 32'h400, 32'h0, 1'b0);
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hA0B0C0D0;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check_cmd("rst_buf_wr", 1'b1, 32'h400, 32'hA0B033D0, 1'b1);
      tick();
      check("rst_buf_done", 32'(bus.done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
